// File: rtl/mac_seq_ctrl_if.sv
// Handshake bundle between a MAC run requester and the mac_seq_ctrl sequencer.
// MAC_SEQ_CTRL_ABORT_EN adds the abort request line.
interface mac_seq_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] len;
`ifdef MAC_SEQ_CTRL_ABORT_EN
  logic                  abort;
`endif
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  acc_clr;
  logic                  acc_en;
  logic                  busy;
  logic                  done;

`ifdef MAC_SEQ_CTRL_ABORT_EN
  modport master (
    output start, len, abort,
    input  rd_en, rd_addr, acc_clr, acc_en, busy, done
  );
  modport slave (
    input  start, len, abort,
    output rd_en, rd_addr, acc_clr, acc_en, busy, done
  );
`else
  modport master (
    output start, len,
    input  rd_en, rd_addr, acc_clr, acc_en, busy, done
  );
  modport slave (
    input  start, len,
    output rd_en, rd_addr, acc_clr, acc_en, busy, done
  );
`endif
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one multiply-accumulate run: clear, stream len operand reads, drain, done.
// Define MAC_SEQ_CTRL_ABORT_EN to enable cancelling an active run via bus.abort.
module mac_seq_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  mac_seq_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StDone} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  acc_clr_q;
  logic                  acc_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  abort_hit;

  // busy_q is high exactly in CLR, RUN and DRAIN, the only states abort may cancel.
`ifdef MAC_SEQ_CTRL_ABORT_EN
  assign abort_hit = bus.abort && busy_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort_hit) begin
      state_q   <= StIdle;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            len_q     <= bus.len;
            acc_clr_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StClr;
          end
        end
        StClr: begin
          acc_clr_q <= 1'b0;
          if (len_q != '0) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            state_q   <= StRun;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StRun: begin
          // acc_en trails each read by one cycle to cover the memory read latency.
          acc_en_q <= 1'b1;
          if (rd_addr_q == len_q - ADDR_WIDTH'(1)) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            state_q   <= StDrain;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
          end
        end
        StDrain: begin
          acc_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.acc_clr = acc_clr_q;
  assign bus.acc_en  = acc_en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed self-checking bench for mac_seq_ctrl; expected outputs follow the run timeline
// relative to the start cycle T (cycle k below means T+k).
module tb_mac_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mac_seq_ctrl_if #(.ADDR_WIDTH(8)) bus ();

  mac_seq_ctrl #(.ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, done, acc_clr, acc_en, rd_en, rd_addr}
  function automatic logic [12:0] obs();
    return {bus.busy, bus.done, bus.acc_clr, bus.acc_en, bus.rd_en, bus.rd_addr};
  endfunction

  function automatic logic [12:0] exp_vec(input int n, input int k);
    logic       b, d, c, e, r;
    logic [7:0] a;
    c = (k == 1);
    r = (n != 0) && (k >= 2) && (k <= n + 1);
    a = r ? 8'(k - 2) : 8'd0;
    e = (n != 0) && (k >= 3) && (k <= n + 2);
    d = (n == 0) ? (k == 2) : (k == n + 3);
    b = (n == 0) ? (k == 1) : ((k >= 1) && (k <= n + 2));
    return {b, d, c, e, r, a};
  endfunction

  // Runs one job; leaves the bench in the idle cycle after done so a following call
  // starts back-to-back. dist_k > 0 pulses start with len=9 at that busy cycle.
  task automatic run(input int n, input int dist_k);
    int last;
    int rd_cnt;
    last   = (n == 0) ? 3 : n + 4;
    rd_cnt = 0;
    bus.start = 1'b1;
    bus.len   = 8'(n);
    tick();
    bus.start = 1'b0;
    bus.len   = 8'hA5;
    for (int k = 1; k <= last; k++) begin
      check_eq($sformatf("len%0d_k%0d", n, k), 32'(obs()), 32'(exp_vec(n, k)));
      if (bus.rd_en) rd_cnt++;
      if (k == dist_k) begin
        bus.start = 1'b1;
        bus.len   = 8'd9;
      end else begin
        bus.start = 1'b0;
      end
      if (k < last) tick();
    end
    check_eq($sformatf("len%0d_rd_count", n), 32'(rd_cnt), 32'(n));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.len   = 8'd0;
`ifdef MAC_SEQ_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    #2;
    check_eq("reset_outputs", 32'(obs()), 32'd0);
    tick();
    tick();
    check_eq("reset_hold", 32'(obs()), 32'd0);

    // Start presented on the very first edge after release.
    rst_n = 1'b1;
    run(4, 0);
    run(0, 0);
    run(3, 2);
    run(2, 0);
    run(1, 0);
    run(255, 0);

    // Reset at T+3 of a len=5 run.
    bus.start = 1'b1;
    bus.len   = 8'd5;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check_eq("pre_rst_k3", 32'(obs()), 32'(exp_vec(5, 3)));
    #2 rst_n = 1'b0;
    #1 check_eq("rst_async", 32'(obs()), 32'd0);
    tick();
    tick();
    check_eq("rst_mid_hold", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("post_rst_idle%0d", i), 32'(obs()), 32'd0);
    end
    run(2, 0);

`ifdef MAC_SEQ_CTRL_ABORT_EN
    // Abort at T+4 of a len=6 run.
    bus.start = 1'b1;
    bus.len   = 8'd6;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("abort_run_k%0d", k), 32'(obs()), 32'(exp_vec(6, k)));
      if (k < 4) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abort_idle", 32'(obs()), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("abort_no_done%0d", i), 32'(obs()), 32'd0);
    end
    // Abort together with start in IDLE must not block the start.
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.len   = 8'd1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check_eq("abort_start_k1", 32'(obs()), 32'(exp_vec(1, 1)));
    for (int k = 2; k <= 5; k++) begin
      tick();
      check_eq($sformatf("abort_start_k%0d", k), 32'(obs()), 32'(exp_vec(1, k)));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
